// File: rtl/pc_unit_pkg.sv
// Shared types for the program-counter unit: FSM states, PC source select
// and the exception-cause width helper.
package pc_unit_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    EXC_SAVE = 2'd1,
    EXC_VEC  = 2'd2
  } pc_state_e;

  typedef enum logic [1:0] {
    PCS_ALU    = 2'd0,
    PCS_ALUOUT = 2'd1,
    PCS_JUMP   = 2'd2,
    PCS_EPC    = 2'd3
  } pc_src_e;

  // One extra code point is reserved for the internal alignment cause.
  function automatic int unsigned cause_w(input int unsigned num_exc);
    return $clog2(num_exc + 1);
  endfunction

endpackage

// File: rtl/pc_unit_exc_prio_enc.sv
// Lowest-index-first priority encoder for the exception request channels.
module exc_prio_enc #(
  parameter int unsigned N  = 2,
  parameter int unsigned CW = 2
) (
  input  logic [N-1:0]  req,
  output logic          valid,
  output logic [CW-1:0] cause
);

  always_comb begin
    valid = 1'b0;
    cause = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i] && !valid) begin
        valid = 1'b1;
        cause = CW'(i);
      end
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: PC/EPC registers, next-PC select and two-cycle
// exception entry. Optional target alignment check: PC_ALIGN_CHECK_EN.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      NUM_EXC   = 2,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [31:0]      EXC_BASE  = 32'h0000_0100
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic                          pc_write,
  input  logic                          pc_write_cond,
  input  logic                          zero,
  input  logic                          branch_ne,
  input  logic [1:0]                    pc_src,
  input  logic [WIDTH-1:0]              alu_result,
  input  logic [WIDTH-1:0]              aluout,
  input  logic [25:0]                   instr_index,
  input  logic [NUM_EXC-1:0]            exc_req,
  output logic [WIDTH-1:0]              pc,
  output logic [WIDTH-1:0]              epc,
  output logic [cause_w(NUM_EXC)-1:0]   exc_cause,
  output logic                          exc_busy,
  output logic [WIDTH-1:0]              bad_addr
);

  localparam int unsigned      CW      = cause_w(NUM_EXC);
  localparam logic [WIDTH-1:0] HI_MASK = {WIDTH{1'b1}} << 28;

  pc_state_e         state_q, state_d;
  logic [WIDTH-1:0]  pc_q, pc_d;
  logic [WIDTH-1:0]  epc_q, epc_d;
  logic [CW-1:0]     cause_q, cause_d;

  pc_src_e           src_sel;
  logic [WIDTH-1:0]  jump_target;
  logic [WIDTH-1:0]  next_pc;
  logic [WIDTH-1:0]  vector;
  logic              we;
  logic              ext_valid;
  logic [CW-1:0]     ext_cause;
  logic              misalign;

  exc_prio_enc #(
    .N  (NUM_EXC),
    .CW (CW)
  ) u_prio (
    .req   (exc_req),
    .valid (ext_valid),
    .cause (ext_cause)
  );

  assign src_sel     = pc_src_e'(pc_src);
  assign jump_target = (pc_q & HI_MASK) | WIDTH'({instr_index, 2'b00});
  assign we          = pc_write | (pc_write_cond & (zero ^ branch_ne));
  assign vector      = WIDTH'(EXC_BASE) + (WIDTH'(cause_q) << 2);

  always_comb begin
    next_pc = alu_result;
    case (src_sel)
      PCS_ALU:    next_pc = alu_result;
      PCS_ALUOUT: next_pc = aluout;
      PCS_JUMP:   next_pc = jump_target;
      PCS_EPC:    next_pc = epc_q;
      default:    next_pc = alu_result;
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  logic [WIDTH-1:0] bad_addr_q, bad_addr_d;

  assign misalign = we && (next_pc[1:0] != 2'b00);

  // Only latch the target when the alignment fault is the cause actually taken.
  always_comb begin
    bad_addr_d = bad_addr_q;
    if (state_q == RUN && misalign && !ext_valid) bad_addr_d = next_pc;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) bad_addr_q <= '0;
    else          bad_addr_q <= bad_addr_d;
  end

  assign bad_addr = bad_addr_q;
`else
  assign misalign = 1'b0;
  assign bad_addr = '0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    case (state_q)
      RUN: begin
        if (ext_valid) begin
          state_d = EXC_SAVE;
          cause_d = ext_cause;
        end else if (misalign) begin
          state_d = EXC_SAVE;
          cause_d = CW'(NUM_EXC);
        end else if (we) begin
          pc_d = next_pc;
        end
      end
      EXC_SAVE: begin
        epc_d   = pc_q - WIDTH'(4);
        state_d = EXC_VEC;
      end
      EXC_VEC: begin
        pc_d    = vector;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= RUN;
      pc_q    <= RESET_VEC;
      epc_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
    end
  end

  assign pc        = pc_q;
  assign epc       = epc_q;
  assign exc_cause = cause_q;
  assign exc_busy  = (state_q != RUN);

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed table, exception/reset sequences
// and randomized traffic against a behavioural reference model.
module tb_pc_unit;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        pc_write, pc_write_cond, zero, branch_ne;
  logic [1:0]  pc_src;
  logic [31:0] alu_result, aluout;
  logic [25:0] instr_index;
  logic [1:0]  exc_req;
  logic [31:0] pc, epc, bad_addr;
  logic [1:0]  exc_cause;
  logic        exc_busy;

  int checks = 0;
  int errors = 0;

  // Reference model state: m_left counts remaining entry cycles (2 = epc pending,
  // 1 = vector pending, 0 = running).
  logic [31:0] m_pc, m_epc, m_bad;
  int          m_cause;
  int          m_left;

  pc_unit #(
    .WIDTH     (32),
    .NUM_EXC   (2),
    .RESET_VEC (32'h0),
    .EXC_BASE  (32'h0000_0100)
  ) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .zero          (zero),
    .branch_ne     (branch_ne),
    .pc_src        (pc_src),
    .alu_result    (alu_result),
    .aluout        (aluout),
    .instr_index   (instr_index),
    .exc_req       (exc_req),
    .pc            (pc),
    .epc           (epc),
    .exc_cause     (exc_cause),
    .exc_busy      (exc_busy),
    .bad_addr      (bad_addr)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        pw, pwc, z, bne;
    logic [1:0]  src;
    logic [31:0] alu, aout;
    logic [25:0] idx;
    logic [31:0] exp_pc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_epc = 32'h0; m_bad = 32'h0; m_cause = 0; m_left = 0;
  endtask

  task automatic model_edge();
    logic        taken;
    logic [31:0] tgt;
    int          lowest;
    if (!Reset_n) begin
      model_reset();
    end else if (m_left == 2) begin
      m_epc  = m_pc - 32'd4;
      m_left = 1;
    end else if (m_left == 1) begin
      m_pc   = 32'h100 + 32'(4 * m_cause);
      m_left = 0;
    end else begin
      taken = pc_write || (pc_write_cond && (zero != branch_ne));
      case (pc_src)
        2'd0:    tgt = alu_result;
        2'd1:    tgt = aluout;
        2'd2:    tgt = {m_pc[31:28], instr_index, 2'b00};
        default: tgt = m_epc;
      endcase
      lowest = -1;
      for (int i = 0; i < 2; i++)
        if (exc_req[i] && lowest < 0) lowest = i;
      if (lowest >= 0) begin
        m_cause = lowest;
        m_left  = 2;
      end
`ifdef PC_ALIGN_CHECK_EN
      else if (taken && tgt[1:0] != 2'b00) begin
        m_cause = 2;
        m_bad   = tgt;
        m_left  = 2;
      end
`endif
      else if (taken) begin
        m_pc = tgt;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".pc"},       pc,                m_pc);
    check({tag, ".epc"},      epc,               m_epc);
    check({tag, ".cause"},    32'(exc_cause),    32'(m_cause));
    check({tag, ".busy"},     32'(exc_busy),     32'(m_left != 0));
    check({tag, ".bad_addr"}, bad_addr,          m_bad);
  endtask

  task automatic cycle(input string tag);
    model_edge();
    @(posedge Clk);
    #1;
    compare_all(tag);
  endtask

  task automatic idle_inputs();
    pc_write = 0; pc_write_cond = 0; zero = 0; branch_ne = 0; pc_src = 2'd0;
    alu_result = '0; aluout = '0; instr_index = '0; exc_req = '0;
  endtask

  vec_t tbl[9];

  initial begin
    tbl[0] = '{1,0,0,0,2'd0,32'h4,         32'h0, 26'h0,   32'h4};
    tbl[1] = '{0,0,0,0,2'd0,32'h8,         32'h0, 26'h0,   32'h4};
    tbl[2] = '{0,1,1,0,2'd1,32'h0,         32'h40,26'h0,   32'h40};
    tbl[3] = '{0,1,0,0,2'd1,32'h0,         32'h80,26'h0,   32'h40};
    tbl[4] = '{0,1,0,1,2'd1,32'h0,         32'h80,26'h0,   32'h80};
    tbl[5] = '{1,0,0,0,2'd0,32'h1000_0008, 32'h0, 26'h0,   32'h1000_0008};
    tbl[6] = '{1,0,0,0,2'd2,32'h0,         32'h0, 26'h100, 32'h1000_0400};
    tbl[7] = '{0,1,1,1,2'd0,32'h44,        32'h0, 26'h0,   32'h1000_0400};
    tbl[8] = '{1,0,0,0,2'd3,32'h0,         32'h0, 26'h0,   32'h0};

    idle_inputs();
    Reset_n = 1'b0;
    model_reset();
    #12;
    check("reset.pc",   pc,             32'h0);
    check("reset.epc",  epc,            32'h0);
    check("reset.busy", 32'(exc_busy),  32'h0);
    check("reset.cause",32'(exc_cause), 32'h0);
    Reset_n = 1'b1;

    foreach (tbl[i]) begin
      pc_write = tbl[i].pw; pc_write_cond = tbl[i].pwc; zero = tbl[i].z;
      branch_ne = tbl[i].bne; pc_src = tbl[i].src; alu_result = tbl[i].alu;
      aluout = tbl[i].aout; instr_index = tbl[i].idx; exc_req = '0;
      cycle("tbl");
      check($sformatf("tbl[%0d].pc", i), pc, tbl[i].exp_pc);
    end

    // Exception entry with a competing pc_write that must be dropped.
    idle_inputs();
    pc_write = 1; alu_result = 32'h24;
    cycle("setpc");
    exc_req = 2'b11; alu_result = 32'h50;
    cycle("exc1");
    check("exc.cause_e1", 32'(exc_cause), 32'h0);
    check("exc.busy_e1",  32'(exc_busy),  32'h1);
    check("exc.pc_e1",    pc,             32'h24);
    exc_req = 2'b00;
    cycle("exc2");
    check("exc.epc_e2",   epc,            32'h20);
    check("exc.busy_e2",  32'(exc_busy),  32'h1);
    check("exc.pc_e2",    pc,             32'h24);
    cycle("exc3");
    check("exc.pc_e3",    pc,             32'h100);
    check("exc.busy_e3",  32'(exc_busy),  32'h0);
    pc_write = 0;
    cycle("hold");
    pc_write = 1; pc_src = 2'd3;
    cycle("eret");
    check("eret.pc",  pc,  32'h20);
    check("eret.epc", epc, 32'h20);

    idle_inputs();
    exc_req = 2'b10;
    cycle("c1a");
    check("c1.cause", 32'(exc_cause), 32'h1);
    exc_req = 2'b00;
    cycle("c1b");
    cycle("c1c");
    check("c1.pc", pc, 32'h104);

    // Misaligned target.
    pc_write = 1; alu_result = 32'h6;
    cycle("al1");
`ifdef PC_ALIGN_CHECK_EN
    check("align.pc_held", pc,             32'h104);
    check("align.cause",   32'(exc_cause), 32'h2);
    check("align.bad",     bad_addr,       32'h6);
    pc_write = 0;
    cycle("al2");
    cycle("al3");
    check("align.vec", pc, 32'h108);
`else
    check("noalign.pc",  pc,       32'h6);
    check("noalign.bad", bad_addr, 32'h0);
    pc_write = 0;
`endif

    // Asynchronous reset in the middle of an exception entry.
    idle_inputs();
    exc_req = 2'b01;
    cycle("rsta");
    #3;
    Reset_n = 1'b0;
    #1;
    check("arst.pc",    pc,             32'h0);
    check("arst.epc",   epc,            32'h0);
    check("arst.busy",  32'(exc_busy),  32'h0);
    check("arst.cause", 32'(exc_cause), 32'h0);
    check("arst.bad",   bad_addr,       32'h0);
    model_reset();
    exc_req = 2'b00;
    cycle("rstb");
    #3;
    Reset_n = 1'b1;

    for (int n = 0; n < 400; n++) begin
      pc_write      = ($urandom_range(0, 2) == 0);
      pc_write_cond = $urandom_range(0, 1);
      zero          = $urandom_range(0, 1);
      branch_ne     = $urandom_range(0, 1);
      pc_src        = 2'($urandom_range(0, 3));
      alu_result    = $urandom;
      aluout        = $urandom;
      if ($urandom_range(0, 3) != 0) alu_result[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) aluout[1:0] = 2'b00;
      instr_index   = 26'($urandom);
      exc_req       = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      cycle("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
